pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic elastic pipeline stage register for the five-stage datapath. Replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one parametrised block.
- Carries a flat payload bus with a valid/ready handshake and an optional 2-entry skid buffer, so back-pressure does not have to be broadcast combinationally.
- Keeps the legacy global stall and flush controls. Adds per-entry kill (bubble) tagging, occupancy reporting and a saturating back-pressure counter.

Parameters:
- DATA_W, 64: payload width in bits.
- CTRL_W, 8: number of payload LSBs that are control (write enables etc.), forced to zero on killed entries. Legal range 0..DATA_W.
- SKID, 1: 1 selects a 2-entry skid buffer with registered oReady; 0 selects a single register with combinational oReady.
- CNT_W, 16: width of the back-pressure counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- iValid  in  1  upstream has a payload.
- oReady  out  1  stage can accept this cycle.
- iData  in  DATA_W  upstream payload.
- iKill  in  1  tag the accepted payload as a bubble.
- iStall  in  1  legacy freeze: no accept, no release.
- iFlush  in  1  discard all held entries and the incoming entry.
- oValid  out  1  stage holds a payload for downstream.
- iReady  in  1  downstream accepts this cycle.
- oData  out  DATA_W  head payload; bits [CTRL_W-1:0] are zero if the head entry is killed.
- oKilled  out  1  head entry is a bubble.
- oCount  out  2  occupancy, 0..2 (max 1 when SKID=0).
- oBpCnt  out  CNT_W  saturating count of cycles with oValid & ~iReady & ~iStall.

Behaviour:
- Storage: main entry M {valid, killed, data}; skid entry S with the same fields (SKID=1 only).
- Reset (reset=1 at the clock edge): M and S valid=0, killed=0, data=0; oBpCnt=0. While reset is high, oReady=0.
- Definitions: acc = iValid & oReady & ~iStall & ~iFlush; rel = oValid & iReady & ~iStall & ~iFlush.
- oValid = M.valid; oData = M.data with the control field masked when M.killed; oKilled = M.valid & M.killed.
- SKID=1 ready: oReady = ~S.valid & ~iStall & ~reset. Registered state only, no path from iReady.
- SKID=0 ready: oReady = (~M.valid | iReady) & ~iStall & ~reset.
- FSM (SKID=1), encoded by {M.valid, S.valid}:
  - EMPTY: acc -> HALF, M<=in.
  - HALF: acc & rel -> HALF, M<=in. acc & ~rel -> FULL, S<=in. ~acc & rel -> EMPTY. Otherwise hold.
  - FULL: rel -> HALF, M<=S, S cleared. No accept in FULL.
- SKID=0: EMPTY/HALF only. acc & rel in the same cycle gives zero-bubble throughput.
- Latency: payload accepted at edge N appears on oData after edge N; 1 cycle through an empty stage.
- Kill tagging: the killed bit is latched with the entry (killed <= iKill) and travels with it through S to M. The data field is stored unmodified; masking is applied only at oData.
- iStall: all state and oBpCnt hold. oReady=0. Downstream must ignore oValid as a transfer, because rel=0.
- iFlush (priority: reset > flush > stall): next edge sets M.valid=S.valid=0 and killed=0. The incoming payload is dropped; data registers may hold stale values.
- oCount = M.valid + S.valid.
- oBpCnt: increments when oValid & ~iReady & ~iStall & ~iFlush. Holds at 2^CNT_W-1 (no wrap).
- Invariant: S.valid implies M.valid. Order is preserved: M is always older than S.

Decomposition:
- Shared package pipe_pkg: occupancy encodings (OCC_EMPTY=0, OCC_HALF=1, OCC_FULL=2) and the default CTRL_W constants per stage boundary (IFID, IDEX, EXMEM, MEMWB).
- Sub-module pipe_sat_counter (CNT_W, inc, clear) is natural for oBpCnt. Entries stay inline.

Test Plan:
- Reset with iValid=1, iData=0xA5 -> oReady=0, oValid=0, oCount=0, oBpCnt=0; one cycle after release oReady=1.
- SKID=1, iReady=1, stream 0x01..0x08 back-to-back -> oData 0x01..0x08 one cycle later, no gaps, oCount constant 1.
- SKID=1, iReady=0, push 0x11, 0x22 -> oCount=2, oReady=0, oBpCnt increments each cycle; raise iReady -> 0x11 then 0x22 in order.
- iKill=1 with iData=0xFFFF_FFFF_FFFF_FFFF, CTRL_W=8 -> oData=0xFFFF_FFFF_FFFF_FF00, oKilled=1; next non-killed entry appears unmasked.
- FULL state, assert iFlush and iStall together with iValid=1 -> next cycle oValid=0, oCount=0, input dropped, oBpCnt unchanged.
- CNT_W=4, hold oValid=1 and iReady=0 for 20 cycles -> oBpCnt saturates at 15; iStall=1 freezes oBpCnt and oData.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers.
package pipe_pkg;

    // Stage occupancy, numerically equal to the number of held entries.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HALF  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Default control-field widths per stage boundary.
    localparam int unsigned CTRL_W_IFID  = 0;
    localparam int unsigned CTRL_W_IDEX  = 8;
    localparam int unsigned CTRL_W_EXMEM = 4;
    localparam int unsigned CTRL_W_MEMWB = 2;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : pipe_sat_counter

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage with optional 2-entry skid buffer,
// bubble tagging, legacy stall/flush, occupancy and back-pressure count.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iValid,
    output logic              oReady,
    input  logic [DATA_W-1:0] iData,
    input  logic              iKill,
    input  logic              iStall,
    input  logic              iFlush,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oData,
    output logic              oKilled,
    output logic [1:0]        oCount,
    output logic [CNT_W-1:0]  oBpCnt
);

    // Low CTRL_W bits set; all-zero when CTRL_W is 0.
    localparam logic [DATA_W-1:0] CTRL_MASK = {DATA_W{1'b1}} >> (DATA_W - CTRL_W);

    // Main (head) entry and skid entry.
    logic              m_valid_q, m_valid_d;
    logic              m_killed_q, m_killed_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              s_valid_q, s_valid_d;
    logic              s_killed_q, s_killed_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;

    logic acc;
    logic rel;
    logic bp_inc;
    occ_e occ;

    // Skid mode derives ready from registered state only; single-register
    // mode lets a downstream accept free the slot in the same cycle.
    assign oReady = (SKID != 0) ? (~s_valid_q & ~iStall & ~reset)
                                : ((~m_valid_q | iReady) & ~iStall & ~reset);

    assign acc    = iValid & oReady & ~iStall & ~iFlush;
    assign rel    = oValid & iReady & ~iStall & ~iFlush;
    assign bp_inc = oValid & ~iReady & ~iStall & ~iFlush;

    assign occ     = occ_e'(2'({1'b0, m_valid_q}) + 2'({1'b0, s_valid_q}));
    assign oCount  = occ;
    assign oValid  = m_valid_q;
    assign oKilled = m_valid_q & m_killed_q;
    assign oData   = m_killed_q ? (m_data_q & ~CTRL_MASK) : m_data_q;

    // Entry next-state: flush clears everything, otherwise move by occupancy.
    always_comb begin
        m_valid_d  = m_valid_q;
        m_killed_d = m_killed_q;
        m_data_d   = m_data_q;
        s_valid_d  = s_valid_q;
        s_killed_d = s_killed_q;
        s_data_d   = s_data_q;

        if (iFlush) begin
            m_valid_d  = 1'b0;
            m_killed_d = 1'b0;
            s_valid_d  = 1'b0;
            s_killed_d = 1'b0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (acc) begin
                        m_valid_d  = 1'b1;
                        m_killed_d = iKill;
                        m_data_d   = iData;
                    end
                end
                OCC_HALF: begin
                    if (acc && rel) begin
                        m_killed_d = iKill;
                        m_data_d   = iData;
                    end else if (acc) begin
                        s_valid_d  = 1'b1;
                        s_killed_d = iKill;
                        s_data_d   = iData;
                    end else if (rel) begin
                        m_valid_d = 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (rel) begin
                        m_killed_d = s_killed_q;
                        m_data_d   = s_data_q;
                        s_valid_d  = 1'b0;
                        s_killed_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end

        // Without a skid buffer the second entry never exists.
        if (SKID == 0) begin
            s_valid_d  = 1'b0;
            s_killed_d = 1'b0;
            s_data_d   = '0;
        end
    end

    // Entry registers; iStall holds naturally since acc and rel are both low.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q  <= 1'b0;
            m_killed_q <= 1'b0;
            m_data_q   <= '0;
            s_valid_q  <= 1'b0;
            s_killed_q <= 1'b0;
            s_data_q   <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_killed_q <= m_killed_d;
            m_data_q   <= m_data_d;
            s_valid_q  <= s_valid_d;
            s_killed_q <= s_killed_d;
            s_data_q   <= s_data_d;
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bp_cnt (
        .clk     (clk),
        .clear_i (reset),
        .inc_i   (bp_inc),
        .count_o (oBpCnt)
    );

endmodule : pipe_stage_reg
